// File: rtl/shift_arbiter_if.sv
// rtl/shift_arbiter_if.sv - requester, shared-shifter and result signals of shift_arbiter
interface shift_arbiter_if;
    logic       req0;
    logic [7:0] d0;
    logic [2:0] amt0;
    logic       gnt0;
    logic       req1;
    logic [7:0] d1;
    logic [2:0] amt1;
    logic       gnt1;
    logic [7:0] sh_d;
    logic [7:0] sh_n;
    logic [7:0] sh_w;
    logic [7:0] res;
    logic       done0;
    logic       done1;
    logic       busy;

    modport slave (
        input  req0, d0, amt0, req1, d1, amt1, sh_w,
        output gnt0, gnt1, sh_d, sh_n, res, done0, done1, busy
    );

    modport master (
        output req0, d0, amt0, req1, d1, amt1, sh_w,
        input  gnt0, gnt1, sh_d, sh_n, res, done0, done1, busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sequencer sharing one slow one-hot left shifter between two requesters
module shift_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [3:0] LAST_CNT  = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       owner;
    logic       ptr;
    logic       gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
    logic [7:0] sh_d_q, sh_n_q, res_q;

    // Requester 1 wins when it is alone or when the pointer favours it.
    logic       pick1;
    logic [7:0] sel_d;
    logic [2:0] sel_amt;

    assign pick1   = bus.req1 & (~bus.req0 | ptr);
    assign sel_d   = pick1 ? bus.d1 : bus.d0;
    assign sel_amt = pick1 ? bus.amt1 : bus.amt0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            owner   <= 1'b0;
            ptr     <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            sh_d_q  <= 8'h00;
            sh_n_q  <= 8'h00;
            res_q   <= 8'h00;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner  <= pick1;
                        ptr    <= ~pick1;
                        sh_d_q <= sel_d;
                        sh_n_q <= 8'd1 << sel_amt;
                        cnt    <= 4'd0;
                        gnt0_q <= ~pick1;
                        gnt1_q <= pick1;
                        busy_q <= 1'b1;
                        state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Shifter inputs have been stable for SETTLE_CYCLES edges here.
                    if (cnt == LAST_CNT) begin
                        res_q   <= bus.sh_w;
                        sh_d_q  <= 8'h00;
                        sh_n_q  <= 8'h00;
                        done0_q <= ~owner;
                        done1_q <= owner;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    sh_d_q <= 8'h00;
                    sh_n_q <= 8'h00;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.busy  = busy_q;
    assign bus.sh_d  = sh_d_q;
    assign bus.sh_n  = sh_n_q;
    assign bus.res   = res_q;
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Sequencer and round-robin arbiter that shares one 8-bit one-hot-controlled left shifter between two requesters. It accepts a binary shift amount and decodes it to the shifter's one-hot control. It holds the shifter inputs stable for a programmable settle window, because the shared shifter is a deep AND-OR chain with large propagation delay. It then captures the result and returns it to the owning requester with a done pulse.

Parameters:
SETTLE_CYCLES, 2, number of clock cycles shifter inputs are held before sh_w is sampled; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req0  input  1  requester 0 operation request; level; held until gnt0.
d0  input  8  requester 0 data operand.
amt0  input  3  requester 0 left-shift amount, 0..7.
req1  input  1  requester 1 request.
d1  input  8  requester 1 data.
amt1  input  3  requester 1 shift amount.
gnt0  output  1  one-cycle pulse: requester 0 operands accepted.
gnt1  output  1  one-cycle pulse: requester 1 operands accepted.
sh_d  output  8  data to shared shifter D input.
sh_n  output  8  one-hot shift select to shared shifter N input.
sh_w  input  8  shifter result W (W = D << k when N = 1<<k).
res  output  8  captured result; valid while done0/done1 is high, held after.
done0  output  1  one-cycle pulse: res belongs to requester 0.
done1  output  1  one-cycle pulse: res belongs to requester 1.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; gnt0, gnt1, done0, done1, busy = 0; sh_d = 0x00; sh_n = 0x00; res = 0x00; settle counter = 0; RR pointer favours requester 0. Any in-flight operation is dropped with no done.
- All outputs are registered; there are no combinational input-to-output paths.
- States: IDLE, SETTLE, DONE.
- IDLE: sh_d = 0, sh_n = 0, so the shifter outputs 0. On an edge with req0 or req1 high:
  - select the winner;
  - latch its d into sh_d and drive sh_n = 1 << amt;
  - record the owner; set the counter to 0;
  - pulse the owner's gnt for the following cycle;
  - go to SETTLE; busy = 1.
- Arbitration:
  - single request: granted;
  - both requesting: the pointer side wins;
  - after any grant the pointer moves to the other requester.
- SETTLE: sh_d and sh_n stay constant. The counter increments each edge. On the edge where counter == SETTLE_CYCLES-1:
  - res <= sh_w;
  - sh_d, sh_n <= 0;
  - the owner's done is set for one cycle;
  - go to DONE.
- DONE: done pulse visible; on the next edge done clears and the state returns to IDLE; busy = 0 from that edge.
- Latency: with the accepting edge as E0, gnt is high E0..E1, done is high E_S..E_{S+1} (S = SETTLE_CYCLES), and the earliest next acceptance is edge E_{S+2}. Throughput is one op per S+2 cycles.
- req is sampled only in IDLE. Requests arriving in SETTLE/DONE wait. The requester must drop req after seeing gnt, or it is treated as a new request at the next IDLE.
- d/amt only need to be valid on the accepting edge; later changes have no effect.
- gnt0 and gnt1 are never both high; done0 and done1 are never both high; gnt and done never overlap.
- res holds its last captured value until the next capture.
- sh_n is always one-hot in SETTLE and all-zero elsewhere.
- Result arithmetic is the shifter's: res = (d << amt) & 0xFF; bits shifted out are lost and zeros fill from the LSB.

Test Plan:
1. Hold rst_n=0 for 3 cycles with random req/d/amt -> all outputs 0, busy 0. Release -> still idle with no req.
2. S=2, req0, d0=0x35, amt0=3 at E0 -> gnt0 high E0..E1; sh_d=0x35, sh_n=0x08 through SETTLE; done0 at E2 with res=0xA8; busy 0 after E3.
3. req0 and req1 both high from reset, each re-requesting after done -> grant order 0,1,0,1. With only req1 active -> req1 granted every time.
4. Boundaries: d=0xFF, amt=0 -> res 0xFF, sh_n 0x01. d=0x03, amt=7 -> res 0x80, sh_n 0x80. d=0x80, amt=1 -> res 0x00.
5. Assert rst_n=0 mid-SETTLE -> sh_n, sh_d, busy go to 0 immediately and no done. After release, with both requesting -> req0 wins (pointer reset).
6. Connect to the gate-level shifter model with SETTLE_CYCLES=4 and sweep all 8 amounts over 32 random d -> every res equals (d<<amt)&0xFF and no gnt/done overlap.
